// File: rtl/mac_operand_sequencer_pkg.sv
// Shared types and helpers for the MAC operand sequencer.
package mac_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } seq_state_t;

  // Width of the MAC accumulator for a given operand width.
  function automatic int unsigned acc_w(input int unsigned dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/mac_operand_sequencer_op_fifo.sv
// Synchronous first-word-fall-through operand FIFO with same-cycle push/pop.
module mac_operand_sequencer_op_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         cnt_q;
  logic                  push, pop;

  assign full_o    = (cnt_q == DepthCnt);
  assign empty_o   = (cnt_q == '0);
  // Writes while full are dropped; reads while empty are ignored.
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; no reset needed since empty/full gate every access.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Buffers host operands, clears the MAC, feeds it len pairs and returns the accumulated result.
module mac_operand_sequencer
  import mac_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  localparam int unsigned AccW      = acc_w(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_wr_en_i,
  input  logic [DATA_WIDTH-1:0] a_wr_data_i,
  output logic                  a_full_o,
  input  logic                  b_wr_en_i,
  input  logic [DATA_WIDTH-1:0] b_wr_data_i,
  output logic                  b_full_o,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  mac_en_o,
  output logic                  mac_clr_o,
  output logic [DATA_WIDTH-1:0] mac_a_o,
  output logic [DATA_WIDTH-1:0] mac_b_o,
  input  logic [AccW-1:0]       mac_cout_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [AccW-1:0]       res_data_o
);

  seq_state_t            state_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  dcnt_q;
  logic                  mac_en_q, mac_clr_q;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_b_q;
  logic                  res_valid_q;
  logic [AccW-1:0]       res_data_q;

  logic [DATA_WIDTH-1:0] a_head, b_head;
  logic                  a_empty, b_empty;
  logic                  pop;

  // A pair leaves both FIFOs together only when the job still needs operands.
  assign pop = (state_q == StRun) && (rem_q != '0) && !a_empty && !b_empty;

  mac_operand_sequencer_op_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_a (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (a_wr_en_i),
    .wr_data_i (a_wr_data_i),
    .rd_en_i   (pop),
    .rd_data_o (a_head),
    .full_o    (a_full_o),
    .empty_o   (a_empty)
  );

  mac_operand_sequencer_op_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo_b (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (b_wr_en_i),
    .wr_data_i (b_wr_data_i),
    .rd_en_i   (pop),
    .rd_data_o (b_head),
    .full_o    (b_full_o),
    .empty_o   (b_empty)
  );

  // Job sequencing FSM with registered MAC controls and result port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      dcnt_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      mac_clr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          mac_en_q <= 1'b0;
          if (start_i) begin
            mac_clr_q <= 1'b1;
            rem_q     <= len_i;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (rem_q == '0) begin
            // Only reached for len=0; the last pop of a non-empty job exits directly.
            mac_en_q <= 1'b0;
            dcnt_q   <= 1'b0;
            state_q  <= StDrain;
          end else if (pop) begin
            mac_a_q  <= a_head;
            mac_b_q  <= b_head;
            mac_en_q <= 1'b1;
            rem_q    <= rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) begin
              dcnt_q  <= 1'b0;
              state_q <= StDrain;
            end
          end else begin
            mac_en_q <= 1'b0;
          end
        end
        StDrain: begin
          // First cycle lets the MAC absorb the final En, second lets Cout settle.
          mac_en_q <= 1'b0;
          if (!dcnt_q) begin
            dcnt_q <= 1'b1;
          end else begin
            res_data_q  <= mac_cout_i;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign mac_en_o    = mac_en_q;
  assign mac_clr_o   = mac_clr_q;
  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule
